// File: rtl/float_to_sc16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_to_sc16_pkg
// Description : Shared field positions, constants and per-lane pipeline state
//               for the fc32 -> sc16 streaming converter.
// Revision    : 1.0 - initial release
// ============================================================================
package float_to_sc16_pkg;

    // IEEE-754 single-precision field positions
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;
    localparam int FRAC_LSB = 0;

    localparam logic [7:0]  EXP_BIAS = 8'd127;
    localparam logic [7:0]  EXP_MAX  = 8'd255;

    localparam logic [15:0] SC16_MAX = 16'h7FFF;
    localparam logic [15:0] SC16_MIN = 16'h8000;

    // Lane classification decided in S1
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,   // zero, denormal, NaN or too small to round up
        CLS_NORM = 2'd1,   // needs align and round
        CLS_SAT  = 2'd2    // infinity or exponent past full scale
    } lane_cls_t;

    // S1/S2 lane state; in S2 the mant field carries the rounded magnitude
    typedef struct packed {
        logic        sign;
        lane_cls_t   cls;
        logic [9:0]  d;      // two's complement exp - bias + scale
        logic [23:0] mant;
        logic        sat;
    } lane_state_t;

endpackage
`default_nettype wire

// File: rtl/float_to_sc16_axis_if.sv
`default_nettype none
// ============================================================================
// Module      : float_to_sc16_axis_if
// Description : fc32 input stream and sc16 output stream of the converter.
// Revision    : 1.0 - initial release
// ============================================================================
interface float_to_sc16_axis_if;
    logic [63:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;

    // Converter side
    modport slave (
        input  i_tdata, i_tlast, i_tvalid,
        output i_tready,
        output o_tdata, o_tlast, o_tvalid,
        input  o_tready
    );

    // Upstream source / downstream sink side
    modport master (
        output i_tdata, i_tlast, i_tvalid,
        input  i_tready,
        input  o_tdata, o_tlast, o_tvalid,
        output o_tready
    );
endinterface
`default_nettype wire

// File: rtl/float_to_sc16_lane.sv
`default_nettype none
// ============================================================================
// Module      : float_to_sc16_lane
// Description : One-lane, three-stage fc32 -> sc16 datapath. S1 classifies,
//               S2 aligns and rounds, S3 applies sign and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module float_to_sc16_lane
    import float_to_sc16_pkg::*;
#(
    parameter int SCALE_EXP = 15
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        i_en1,
    input  wire logic        i_en2,
    input  wire logic        i_en3,
    input  wire logic [31:0] i_din,
    output logic      [15:0] o_dout,
    output logic             o_sat
);

    logic [7:0]        w_exp;
    logic [22:0]       w_frac;
    logic signed [9:0] w_d;
    lane_state_t       w_s1, r_s1;
    lane_state_t       w_s2, r_s2;
    logic [4:0]        w_sh;
    logic [24:0]       w_t;
    logic [15:0]       w_out, r_out;
    logic              w_sat, r_sat;
    logic              w_unused_d;

    assign w_exp  = i_din[EXP_MSB:EXP_LSB];
    assign w_frac = i_din[FRAC_MSB:FRAC_LSB];
    assign w_d    = $signed({2'b00, w_exp}) - $signed({2'b00, EXP_BIAS})
                  + $signed(10'(SCALE_EXP));

    // S1: unpack and classify; exact -32768 (d==15, frac==0) is not a clamp
    always_comb begin
        w_s1      = '0;
        w_s1.sign = i_din[SIGN_BIT];
        w_s1.d    = w_d;
        w_s1.mant = {1'b1, w_frac};
        w_s1.cls  = CLS_NORM;
        w_s1.sat  = 1'b0;
        if (w_exp == 8'd0) begin
            w_s1.cls = CLS_ZERO;
        end else if (w_exp == EXP_MAX) begin
            if (w_frac != 23'd0) begin
                w_s1.cls = CLS_ZERO;
            end else begin
                w_s1.cls = CLS_SAT;
                w_s1.sat = 1'b1;
            end
        end else if (w_d < -10'sd1) begin
            w_s1.cls = CLS_ZERO;
        end else if (w_d >= 10'sd15) begin
            w_s1.cls = CLS_SAT;
            w_s1.sat = !(i_din[SIGN_BIT] && (w_d == 10'sd15) && (w_frac == 23'd0));
        end
    end

    // S2: shift so the 2^-1 bit lands in w_t[0], then round half away from zero
    assign w_sh = 5'(10'd23 - r_s1.d);
    assign w_t  = {r_s1.mant, 1'b0} >> w_sh;

    always_comb begin
        w_s2      = r_s1;
        w_s2.mant = (r_s1.cls == CLS_NORM) ? (w_t[24:1] + 24'(w_t[0])) : 24'd0;
    end

    // S3: sign and saturation; a negative magnitude of 0 negates to 0x0000
    always_comb begin
        w_out = 16'd0;
        w_sat = r_s2.sat;
        case (r_s2.cls)
            CLS_SAT:  w_out = r_s2.sign ? SC16_MIN : SC16_MAX;
            CLS_NORM: begin
                if (!r_s2.sign) begin
                    if (r_s2.mant > 24'd32767) begin
                        w_out = SC16_MAX;
                        w_sat = 1'b1;
                    end else begin
                        w_out = r_s2.mant[15:0];
                    end
                end else begin
                    w_out = 16'(-r_s2.mant);
                end
            end
            default:  w_out = 16'd0;
        endcase
    end

    assign w_unused_d = ^r_s2.d;

    // Stage registers, each advancing on its own enable
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_out <= 16'd0;
            r_sat <= 1'b0;
        end else begin
            if (i_en1) r_s1 <= w_s1;
            if (i_en2) r_s2 <= w_s2;
            if (i_en3) begin
                r_out <= w_out;
                r_sat <= w_sat;
            end
        end
    end

    assign o_dout = r_out;
    assign o_sat  = r_sat;

endmodule
`default_nettype wire

// File: rtl/float_to_sc16_axis.sv
`default_nettype none
// ============================================================================
// Module      : float_to_sc16_axis
// Description : Streaming fc32 (I/Q floats) to sc16 converter, 3-stage
//               pipeline at one beat per clock with AXI-stream handshakes.
//               Optional saturation counter: FLOAT_TO_SC16_SATCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module float_to_sc16_axis
    import float_to_sc16_pkg::*;
#(
    parameter int SCALE_EXP = 15
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    float_to_sc16_axis_if.slave axis
`ifdef FLOAT_TO_SC16_SATCNT_EN
    ,
    input  wire logic          sat_clear,
    output logic        [15:0] sat_count
`endif
);

    logic        r_v1, r_v2, r_v3;
    logic        r_l1, r_l2, r_l3;
    logic        w_rdy1, w_rdy2, w_rdy3;
    logic        w_en1, w_en2, w_en3;
    logic [15:0] w_dout_i, w_dout_q;
    logic        w_sat_i, w_sat_q;

    // A stage may load when empty or when the stage after it is taking its beat
    assign w_rdy3 = !r_v3 || axis.o_tready;
    assign w_rdy2 = !r_v2 || w_rdy3;
    assign w_rdy1 = !r_v1 || w_rdy2;

    // Data registers only load real beats so they hold steady across bubbles
    assign w_en1 = w_rdy1 && axis.i_tvalid;
    assign w_en2 = w_rdy2 && r_v1;
    assign w_en3 = w_rdy3 && r_v2;

    // Valid and tlast pipeline
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_l1 <= 1'b0;
            r_l2 <= 1'b0;
            r_l3 <= 1'b0;
        end else begin
            if (w_rdy1) r_v1 <= axis.i_tvalid;
            if (w_rdy2) r_v2 <= r_v1;
            if (w_rdy3) r_v3 <= r_v2;
            if (w_en1)  r_l1 <= axis.i_tlast;
            if (w_en2)  r_l2 <= r_l1;
            if (w_en3)  r_l3 <= r_l2;
        end
    end

    float_to_sc16_lane #(.SCALE_EXP(SCALE_EXP)) u_lane_i (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en1   (w_en1),
        .i_en2   (w_en2),
        .i_en3   (w_en3),
        .i_din   (axis.i_tdata[63:32]),
        .o_dout  (w_dout_i),
        .o_sat   (w_sat_i)
    );

    float_to_sc16_lane #(.SCALE_EXP(SCALE_EXP)) u_lane_q (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en1   (w_en1),
        .i_en2   (w_en2),
        .i_en3   (w_en3),
        .i_din   (axis.i_tdata[31:0]),
        .o_dout  (w_dout_q),
        .o_sat   (w_sat_q)
    );

    assign axis.i_tready = w_rdy1;
    assign axis.o_tdata  = {w_dout_i, w_dout_q};
    assign axis.o_tlast  = r_l3;
    assign axis.o_tvalid = r_v3;

`ifdef FLOAT_TO_SC16_SATCNT_EN
    logic [15:0] r_sat_count;

    // Sticky saturation counter; clear takes priority over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sat_count <= 16'd0;
        end else if (sat_clear) begin
            r_sat_count <= 16'd0;
        end else if (r_v3 && axis.o_tready && (w_sat_i || w_sat_q)
                     && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`else
    logic w_unused_sat;
    assign w_unused_sat = w_sat_i | w_sat_q;
`endif

endmodule
`default_nettype wire

// File: doc/float_to_sc16_axis.md
Name: float_to_sc16_axis

Overview:
Streaming converter from fc32 complex samples (IEEE-754 single I and Q) to sc16 samples for the radio TX/DSP path. It sits between the host-side fc32 framing logic and the sc16 DSP chain. It is fully pipelined at one sample per clock, with AXI-stream handshakes on both sides.

Parameters:
SCALE_EXP, 15, power-of-two gain applied before integer conversion (out = round(x * 2^SCALE_EXP)); legal range 0..15.

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
i_tdata  input  64  [63:32] I float, [31:0] Q float
i_tlast  input  1  end of packet
i_tvalid  input  1  input valid
i_tready  output  1  input ready
o_tdata  output  32  [31:16] I sc16, [15:0] Q sc16, two's complement
o_tlast  output  1  end of packet, aligned with its sample
o_tvalid  output  1  output valid
o_tready  input  1  output ready

Behaviour:
- Reset (reset_n low at clk edge): all stage valids clear; o_tvalid=0; o_tdata=0; o_tlast=0. i_tready=1 from the first cycle after reset release. An in-flight sample is discarded, never partially emitted.
- Pipeline has 3 registered stages. S1 unpacks and classifies (zero/denorm, inf, NaN, exponent delta d = exp-127+SCALE_EXP). S2 aligns and rounds the magnitude. S3 applies sign and saturation, and holds the output register.
- Latency: a beat accepted at cycle N appears on o_* at cycle N+3 when o_tready has been held high.
- Throughput: 1 beat/clk. Stages advance when the next stage is empty or draining (bubble collapse).
- i_tready = !S1_valid || S1 advances. A stall of S3 propagates back within the same cycle; no beat is dropped or duplicated.
- o_tdata and o_tlast must hold stable while o_tvalid=1 and o_tready=0.
- Per-lane arithmetic, where m = 1.frac (24 bits):
  - exp==0 (zero/denorm) -> 0.
  - NaN (exp==255, frac!=0) -> 0.
  - +inf -> 0x7FFF; -inf -> 0x8000.
  - d < -1 -> 0.
  - d >= 15 -> saturate: positive 0x7FFF; negative 0x8000.
  - Otherwise: magnitude = m shifted so that the bit at weight 2^-1 is the round bit. Round half away from zero. A rounded positive 32768 clamps to 0x7FFF. A rounded negative 32768 gives 0x8000 and is not saturation.
  - A negative result whose magnitude rounds to 0 gives 0x0000; -0 is never produced.
- Saturation event: a lane's output was clamped, or the lane was inf. Exact -32768 does not count.
- I and Q are independent lanes. tlast travels in lockstep with the data.

Optional Feature:
FLOAT_TO_SC16_SATCNT_EN
- Defined: adds ports sat_clear (input, 1) and sat_count (output, 16).
- sat_count increments by 1 for each output handshake (o_tvalid && o_tready) where either lane saturated. It sticks at 0xFFFF.
- sat_clear zeroes the count. If sat_clear and an increment occur in the same cycle, clear wins. Reset sets sat_count to 0.
- Not defined: no extra ports or logic, and identical datapath behaviour.

Decomposition:
- Package float_to_sc16_pkg holds:
  - field positions (sign 31, exp 30:23, frac 22:0);
  - EXP_BIAS=127, EXP_MAX=255;
  - SC16_MAX=16'h7FFF, SC16_MIN=16'h8000;
  - a struct for the S1/S2 lane state (sign, class, d, mantissa, sat flag).
- Sub-module float_to_sc16_lane: a one-lane 3-stage datapath with per-stage enable inputs, instantiated twice. The top level owns the valid/ready control, tlast, and the optional counter.

Test Plan:
- SCALE_EXP=15, o_tready=1:
  - I=0x3F000000 (0.5), Q=0xBF000000 (-0.5) -> o_tdata=0x4000C000 at accept+3.
  - I=0x3F800000 (1.0), Q=0xBF800000 (-1.0) -> 0x7FFF8000; sat_count +1 (I lane only).
- Special values:
  - I=0x7FC00000 (NaN), Q=0xFF800000 (-inf) -> 0x00008000.
  - I=0x00000001 (denorm), Q=0x80000000 (-0) -> 0x00000000.
- Rounding:
  - I=0x37800000 (2^-16 -> 0.5 LSB), Q=0xB7800000 -> 0x0001FFFF.
  - I=0x37000000 (0.25 LSB) -> 0x0000.
- Backpressure: a 16-beat packet with tlast on beat 15, with o_tready toggling in a pseudo-random pattern -> all 16 outputs in order, no loss or duplication, tlast only on the 16th, o_tdata stable while stalled.
- Reset mid-packet: drop reset_n for 1 cycle with 3 beats in flight -> o_tvalid=0 the next cycle, none of those beats emitted, sat_count=0. The next accepted beat appears with latency 3.
- Counter: hold sat_clear=1 in the same cycle as a saturating handshake -> sat_count=0. After 65536+ saturating beats -> sat_count=0xFFFF.
